// File: rtl/vga_text_pkg.sv
// +--------------------------------------------------------------------+
// | vga_text_pkg : shared constants, types and attribute decode        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vga_text_pkg;

   localparam int ATTR_BG_B = 0;
   localparam int ATTR_BG_G = 1;
   localparam int ATTR_BG_R = 2;
   localparam int ATTR_BG_I = 3;
   localparam int ATTR_FG_B = 4;
   localparam int ATTR_FG_G = 5;
   localparam int ATTR_FG_R = 6;
   localparam int ATTR_FG_I = 7;

   // 640x480@60 defaults
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int PIPE_LATENCY     = 5;
   localparam int BLINK_FRAMES_DEF = 16;

   typedef struct packed {
      logic de;
      logic text;
      logic hs;
      logic vs;
      logic fs;
      logic cur;
   } pix_ctl_t;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // ch: 0 = red, 1 = green, 2 = blue; MSB carries the base bit, the rest base & intensity
   function automatic logic [15:0] attr_chan(input logic [7:0] attr, input logic fg,
                                             input int ch, input int bits);
      logic        base;
      logic        inten;
      logic [15:0] lvl;
      base  = fg ? attr[ATTR_FG_R - ch] : attr[ATTR_BG_R - ch];
      inten = fg ? attr[ATTR_FG_I] : attr[ATTR_BG_I];
      lvl   = '0;
      for (int i = 0; i < 16; i++) begin
         if (i == bits - 1)
            lvl[i] = base;
         else if (i < bits - 1)
            lvl[i] = base & inten;
      end
      return lvl;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +--------------------------------------------------------------------+
// | vga_timing_gen : h/v counters, sync/active flags, cell sub-counters|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
   import vga_text_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int CHAR_W   = 8,
   parameter int CHAR_H   = 16,
   parameter int COLS     = 80,
   parameter int ROWS     = 30,
   parameter int HCW      = 10,
   parameter int VCW      = 10,
   parameter int SXW      = 3,
   parameter int SYW      = 4
)(
   input  logic           clk,
   input  logic           rst_n,
   output logic           active,
   output logic           text_valid,
   output logic           hsync_act,
   output logic           vsync_act,
   output logic           frame_start,
   output logic [HCW-1:0] col,
   output logic [VCW-1:0] row,
   output logic [SXW-1:0] subx,
   output logic [SYW-1:0] suby
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [HCW-1:0] r_h;
   logic [VCW-1:0] r_v;
   logic [HCW-1:0] r_col;
   logic [VCW-1:0] r_row;
   logic [SXW-1:0] r_subx;
   logic [SYW-1:0] r_suby;

   // col/row advance alongside h/v so no divider is needed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_h    <= '0;
         r_v    <= '0;
         r_col  <= '0;
         r_row  <= '0;
         r_subx <= '0;
         r_suby <= '0;
      end else if (r_h == HCW'(H_TOTAL - 1)) begin
         r_h    <= '0;
         r_col  <= '0;
         r_subx <= '0;
         if (r_v == VCW'(V_TOTAL - 1)) begin
            r_v    <= '0;
            r_row  <= '0;
            r_suby <= '0;
         end else begin
            r_v <= r_v + 1'b1;
            if (r_suby == SYW'(CHAR_H - 1)) begin
               r_suby <= '0;
               r_row  <= r_row + 1'b1;
            end else begin
               r_suby <= r_suby + 1'b1;
            end
         end
      end else begin
         r_h <= r_h + 1'b1;
         if (r_subx == SXW'(CHAR_W - 1)) begin
            r_subx <= '0;
            r_col  <= r_col + 1'b1;
         end else begin
            r_subx <= r_subx + 1'b1;
         end
      end
   end

   assign active      = (r_h < HCW'(H_ACTIVE)) && (r_v < VCW'(V_ACTIVE));
   assign text_valid  = active && (r_col < HCW'(COLS)) && (r_row < VCW'(ROWS));
   assign hsync_act   = (r_h >= HCW'(H_ACTIVE + H_FP)) && (r_h < HCW'(H_ACTIVE + H_FP + H_SYNC));
   assign vsync_act   = (r_v >= VCW'(V_ACTIVE + V_FP)) && (r_v < VCW'(V_ACTIVE + V_FP + V_SYNC));
   assign frame_start = (r_h == '0) && (r_v == '0);
   assign col         = r_col;
   assign row         = r_row;
   assign subx        = r_subx;
   assign suby        = r_suby;

endmodule

`default_nettype wire

// File: rtl/vga_text_ctrl.sv
// +--------------------------------------------------------------------+
// | vga_text_ctrl : text-mode VGA controller, 5-stage render pipeline  |
// | Optional blinking cursor: VGA_TEXT_CURSOR_EN       Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_text_ctrl
   import vga_text_pkg::*;
#(
   parameter int   H_ACTIVE    = DEF_H_ACTIVE,
   parameter int   H_FP        = DEF_H_FP,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BP        = DEF_H_BP,
   parameter int   V_ACTIVE    = DEF_V_ACTIVE,
   parameter int   V_FP        = DEF_V_FP,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BP        = DEF_V_BP,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   CHAR_W      = 8,
   parameter int   CHAR_H      = 16,
   parameter int   COLS        = 80,
   parameter int   ROWS        = 30,
   parameter int   CHAR_OFFSET = 32,
   parameter int   COLOR_BITS  = 4,
   parameter int   CELL_AW     = 12,
   parameter int   FONT_AW     = 11
)(
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [CELL_AW-1:0]    cell_addr,
   input  logic [7:0]            cell_char,
   input  logic [7:0]            cell_attr,
   output logic [FONT_AW-1:0]    font_addr,
   input  logic [CHAR_W-1:0]     font_row,
   input  logic [6:0]            cursor_col,
   input  logic [4:0]            cursor_row,
   output logic [COLOR_BITS-1:0] r_o,
   output logic [COLOR_BITS-1:0] g_o,
   output logic [COLOR_BITS-1:0] b_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  de_o,
   output logic                  frame_start_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HCW     = width_of(H_TOTAL);
   localparam int VCW     = width_of(V_TOTAL);
   localparam int SXW     = width_of(CHAR_W);
   localparam int SYW     = width_of(CHAR_H);
   localparam int NSTG    = PIPE_LATENCY - 1;

   logic           w_active, w_text, w_hs, w_vs, w_fs, w_cur_hit, w_pixel;
   logic [HCW-1:0] w_col;
   logic [VCW-1:0] w_row;
   logic [SXW-1:0] w_subx;
   logic [SYW-1:0] w_suby;
   logic [7:0]     w_code;
   pix_ctl_t       w_ctl0;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .CHAR_W   (CHAR_W),   .CHAR_H (CHAR_H), .COLS (COLS), .ROWS (ROWS),
      .HCW      (HCW),      .VCW (VCW),       .SXW (SXW),   .SYW (SYW)
   ) u_timing (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (w_active),
      .text_valid  (w_text),
      .hsync_act   (w_hs),
      .vsync_act   (w_vs),
      .frame_start (w_fs),
      .col         (w_col),
      .row         (w_row),
      .subx        (w_subx),
      .suby        (w_suby)
   );

`ifdef VGA_TEXT_CURSOR_EN
   localparam int BLINK_FRAMES = BLINK_FRAMES_DEF;
   localparam int FCW          = width_of(BLINK_FRAMES + 1);

   logic [6:0]     r_cur_col;
   logic [4:0]     r_cur_row;
   logic [FCW-1:0] r_frame_cnt;
   logic           r_blink_off;

   // Counter runs 1..BLINK_FRAMES so the phase flips at the start of every BLINK_FRAMES-th frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cur_col   <= '0;
         r_cur_row   <= '0;
         r_frame_cnt <= '0;
         r_blink_off <= 1'b0;
      end else if (w_fs) begin
         r_cur_col <= cursor_col;
         r_cur_row <= cursor_row;
         if (r_frame_cnt == FCW'(BLINK_FRAMES)) begin
            r_frame_cnt <= FCW'(1);
            r_blink_off <= ~r_blink_off;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign w_cur_hit = !r_blink_off && (32'(w_col) == 32'(r_cur_col)) &&
                      (32'(w_row) == 32'(r_cur_row)) && (w_suby >= SYW'(CHAR_H - 2));
`else
   logic w_unused_cursor;
   assign w_unused_cursor = ^{cursor_col, cursor_row};
   assign w_cur_hit       = 1'b0;
`endif

   always_comb begin
      w_ctl0      = '0;
      w_ctl0.de   = w_active;
      w_ctl0.text = w_text;
      w_ctl0.hs   = w_hs;
      w_ctl0.vs   = w_vs;
      w_ctl0.fs   = w_fs;
      w_ctl0.cur  = w_cur_hit;
   end

   logic [CELL_AW-1:0]    r_cell_addr;
   logic [FONT_AW-1:0]    r_font_addr;
   pix_ctl_t              r_ctl  [NSTG];
   logic [SXW-1:0]        r_subx [NSTG];
   logic [SYW-1:0]        r_suby1, r_suby2;
   logic [7:0]            r_attr3, r_attr4;
   logic [COLOR_BITS-1:0] r_red, r_grn, r_blu;
   logic                  r_hsync, r_vsync, r_de, r_fstart;

   assign w_code  = cell_char - 8'(CHAR_OFFSET);
   assign w_pixel = font_row[r_subx[NSTG-1]] | r_ctl[NSTG-1].cur;

   // Stage k of r_ctl/r_subx holds the counter state from k+1 cycles ago
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cell_addr <= '0;
         r_font_addr <= '0;
         for (int i = 0; i < NSTG; i++) begin
            r_ctl[i]  <= '0;
            r_subx[i] <= '0;
         end
         r_suby1  <= '0;
         r_suby2  <= '0;
         r_attr3  <= '0;
         r_attr4  <= '0;
         r_red    <= '0;
         r_grn    <= '0;
         r_blu    <= '0;
         r_hsync  <= ~SYNC_POL;
         r_vsync  <= ~SYNC_POL;
         r_de     <= 1'b0;
         r_fstart <= 1'b0;
      end else begin
         r_cell_addr <= w_text ? CELL_AW'(32'(w_row) * 32'(COLS) + 32'(w_col)) : '0;
         r_ctl[0]    <= w_ctl0;
         r_subx[0]   <= w_subx;
         for (int i = 1; i < NSTG; i++) begin
            r_ctl[i]  <= r_ctl[i-1];
            r_subx[i] <= r_subx[i-1];
         end
         r_suby1     <= w_suby;
         r_suby2     <= r_suby1;
         r_font_addr <= FONT_AW'(32'(w_code) * 32'(CHAR_H) + 32'(r_suby2));
         r_attr3     <= cell_attr;
         r_attr4     <= r_attr3;

         r_de     <= r_ctl[NSTG-1].de;
         r_fstart <= r_ctl[NSTG-1].fs;
         r_hsync  <= r_ctl[NSTG-1].hs ? SYNC_POL : ~SYNC_POL;
         r_vsync  <= r_ctl[NSTG-1].vs ? SYNC_POL : ~SYNC_POL;
         if (r_ctl[NSTG-1].text) begin
            r_red <= COLOR_BITS'(attr_chan(r_attr4, w_pixel, 0, COLOR_BITS));
            r_grn <= COLOR_BITS'(attr_chan(r_attr4, w_pixel, 1, COLOR_BITS));
            r_blu <= COLOR_BITS'(attr_chan(r_attr4, w_pixel, 2, COLOR_BITS));
         end else begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
         end
      end
   end

   assign cell_addr     = r_cell_addr;
   assign font_addr     = r_font_addr;
   assign r_o           = r_red;
   assign g_o           = r_grn;
   assign b_o           = r_blu;
   assign hsync_o       = r_hsync;
   assign vsync_o       = r_vsync;
   assign de_o          = r_de;
   assign frame_start_o = r_fstart;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_vga_text_ctrl : directed checks on a reduced 80x55 timing       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vga_text_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] cell_addr;
   logic [7:0]  cell_char = 8'h00;
   logic [7:0]  cell_attr = 8'h00;
   logic [10:0] font_addr;
   logic [7:0]  font_row = 8'h00;
   logic [6:0]  cursor_col = 7'd0;
   logic [4:0]  cursor_row = 5'd0;
   logic [3:0]  r_o, g_o, b_o;
   logic        hsync_o, vsync_o, de_o, frame_start_o;

   logic [7:0]  scr_char [4096];
   logic [7:0]  scr_attr [4096];
   logic [7:0]  font_rom [2048];

   int err_cnt = 0;
   int chk_cnt = 0;
   int tt      = 0;
   int lows;

   always #5 clk = ~clk;

   vga_text_ctrl #(
      .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3),
      .SYNC_POL (1'b0), .CHAR_W (8), .CHAR_H (16), .COLS (7), .ROWS (2),
      .CHAR_OFFSET (32), .COLOR_BITS (4), .CELL_AW (12), .FONT_AW (11)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cell_addr     (cell_addr),
      .cell_char     (cell_char),
      .cell_attr     (cell_attr),
      .font_addr     (font_addr),
      .font_row      (font_row),
      .cursor_col    (cursor_col),
      .cursor_row    (cursor_row),
      .r_o           (r_o),
      .g_o           (g_o),
      .b_o           (b_o),
      .hsync_o       (hsync_o),
      .vsync_o       (vsync_o),
      .de_o          (de_o),
      .frame_start_o (frame_start_o)
   );

   // 1-cycle latency screen/attr RAM and font ROM
   always @(posedge clk) begin
      cell_char <= scr_char[cell_addr];
      cell_attr <= scr_attr[cell_addr];
      font_row  <= font_rom[font_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (tt=%0d)", tag, got, exp, tt);
      end
   endtask

   // tt counts negedges since release; at tt=k the counter-cycle k address and pixel k-4 are visible
   task automatic step_to(input int target);
      while (tt < target) begin
         @(negedge clk);
         tt++;
      end
   endtask

   function automatic logic [31:0] rgb();
      return 32'({r_o, g_o, b_o});
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) begin
         scr_char[i] = 8'h20;
         scr_attr[i] = 8'h07;
      end
      for (int i = 0; i < 2048; i++) font_rom[i] = 8'h00;
      scr_char[0] = 8'h41; scr_attr[0] = 8'h9A;
      scr_char[1] = 8'h41; scr_attr[1] = 8'h41;
      scr_char[7] = 8'h42; scr_attr[7] = 8'hF0;
      font_rom[528] = 8'h01;
      font_rom[529] = 8'h80;
      font_rom[544] = 8'hFF;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tt = -1;
      step_to(290);

      // mid-line reset
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_rgb",       rgb(),                 32'h0);
      check("rst_de",        32'(de_o),             32'h0);
      check("rst_fs",        32'(frame_start_o),    32'h0);
      check("rst_hsync",     32'(hsync_o),          32'h1);
      check("rst_vsync",     32'(vsync_o),          32'h1);
      check("rst_cell_addr", 32'(cell_addr),        32'h0);
      check("rst_font_addr", 32'(font_addr),        32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tt = -1;

      step_to(0);  check("cell_addr_0", 32'(cell_addr), 32'd0);
                   check("fs_early0", 32'(frame_start_o), 32'h0);
      step_to(2);  check("font_addr_A0", 32'(font_addr), 32'd528);
      step_to(3);  check("fs_early3", 32'(frame_start_o), 32'h0);
      step_to(4);  check("fs_pulse", 32'(frame_start_o), 32'h1);
                   check("de_first", 32'(de_o), 32'h1);
                   check("pix_0_0", rgb(), 32'h00F);
      for (int x = 1; x < 8; x++) begin
         step_to(x + 4);
         check("pix_bg_green", rgb(), 32'h0F0);
         if (x == 1) check("fs_one_cycle", 32'(frame_start_o), 32'h0);
         if (x == 4) check("cell_addr_col1", 32'(cell_addr), 32'd1);
      end
      step_to(12); check("pix_8_0_red", rgb(), 32'h800);
      step_to(13); check("pix_9_0_blue", rgb(), 32'h008);
      step_to(59); check("pix_55_0_fill", rgb(), 32'h888);
      step_to(60); check("pix_56_0_border", rgb(), 32'h000);
                   check("de_border", 32'(de_o), 32'h1);
      step_to(67); check("de_last", 32'(de_o), 32'h1);
      step_to(68); check("de_blank", 32'(de_o), 32'h0);
      step_to(71); check("hsync_before", 32'(hsync_o), 32'h1);
      step_to(72); check("hsync_start", 32'(hsync_o), 32'h0);
      step_to(79); check("hsync_end", 32'(hsync_o), 32'h0);
      step_to(80); check("hsync_after", 32'(hsync_o), 32'h1);
      step_to(82); check("font_addr_A1", 32'(font_addr), 32'd529);
      step_to(84); check("pix_0_1", rgb(), 32'h0F0);
      step_to(91); check("pix_7_1", rgb(), 32'h00F);

      lows = 0;
      for (int k = 164; k < 244; k++) begin
         step_to(k);
         if (!hsync_o) lows++;
      end
      check("hsync_width", 32'(lows), 32'd8);

      step_to(1282); check("font_addr_B0", 32'(font_addr), 32'd544);
      step_to(1284); check("pix_0_16", rgb(), 32'hFFF);
      step_to(1291); check("pix_7_16", rgb(), 32'hFFF);
      step_to(1292); check("pix_8_16", rgb(), 32'h888);
      step_to(1328); check("cell_addr_r1c6", 32'(cell_addr), 32'd13);
      step_to(2570); check("cell_addr_border", 32'(cell_addr), 32'd0);
      step_to(3214); check("pix_border_row", rgb(), 32'h000);
                     check("de_border_row", 32'(de_o), 32'h1);
      step_to(3924); check("vsync_before", 32'(vsync_o), 32'h1);
      step_to(4004); check("vsync_start", 32'(vsync_o), 32'h0);
                     check("de_vblank", 32'(de_o), 32'h0);
      step_to(4163); check("vsync_end", 32'(vsync_o), 32'h0);
      step_to(4164); check("vsync_after", 32'(vsync_o), 32'h1);
      step_to(4403); check("fs_pre_frame", 32'(frame_start_o), 32'h0);
      step_to(4404); check("fs_next_frame", 32'(frame_start_o), 32'h1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
- Parametrised text-mode VGA controller: a sync timing generator plus a character-cell rendering pipeline, all in one pixel-clock domain.
- Drives external synchronous screen RAM, attribute RAM and font ROM read ports, each with 1-cycle read latency.
- Decodes the 8-bit attribute into fg/bg colour and outputs RGB, hsync, vsync and de, with sync aligned to pixel data.
- Successor to the fixed 640x480/80-column generator: timing, cell geometry and colour depth are parameters; adds pipeline alignment, data enable and a frame strobe.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clk)
H_SYNC, 96, hsync width (clk)
H_BP, 48, horizontal back porch (clk)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync
CHAR_W, 8, cell width in pixels
CHAR_H, 16, cell height in lines
COLS, 80, text columns
ROWS, 30, text rows
CHAR_OFFSET, 32, subtracted from char code before font lookup
COLOR_BITS, 4, bits per colour channel (>=2)
CELL_AW, 12, cell address width (>= clog2(COLS*ROWS))
FONT_AW, 11, font address width

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
cell_addr  out  CELL_AW  screen/attr RAM read address
cell_char  in  8  char code; valid 1 cycle after its cell_addr
cell_attr  in  8  attribute; valid 1 cycle after its cell_addr
font_addr  out  FONT_AW  font ROM address
font_row  in  CHAR_W  font row bits, LSB = leftmost pixel; valid 1 cycle after font_addr
cursor_col  in  7  cursor column
cursor_row  in  5  cursor row
r_o, g_o, b_o  out  COLOR_BITS each  pixel colour
hsync_o  out  1  horizontal sync
vsync_o  out  1  vertical sync
de_o  out  1  data enable (active area)
frame_start_o  out  1  1-cycle pulse coincident with output of pixel (0,0)

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is synchronous and active-low.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), where H_TOTAL = sum of H_* and V_TOTAL = sum of V_*. h wraps to 0 and v increments at h = H_TOTAL-1; v wraps after V_TOTAL-1. Position 0 is the first active pixel.
- Horizontal sync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vertical sync uses the same form with V_*.
- Active area: h < H_ACTIVE and v < V_ACTIVE.
- col = h / CHAR_W, subx = h % CHAR_W, row = v / CHAR_H, suby = v % CHAR_H. Implemented as incremental sub-counters, not dividers.
- Stage timing for counter cycle t:
  - cell_addr registered, visible at t+1: row*COLS + col when text_valid, else 0.
  - cell_char/cell_attr sampled at t+2.
  - font_addr visible at t+3: ((cell_char - CHAR_OFFSET) mod 256)*CHAR_H + suby, truncated to FONT_AW.
  - font_row sampled at t+4.
  - Outputs registered, visible at t+5.
- Total latency: 5 clk. hsync/vsync/de/frame_start are delayed 5 cycles so they align with pixel data. Attribute and subx are carried along the pipeline to match.
- text_valid = active and col < COLS and row < ROWS. Active pixels outside text_valid output 0 with de_o = 1 (border). Outside the active area RGB = 0 and de_o = 0.
- pixel = font_row[subx]; colour = pixel ? fg : bg.
- Attribute decode (per channel):
  - fg base bits attr[6:4] = R,G,B; fg intensity attr[7]. bg base bits attr[2:0]; bg intensity attr[3].
  - Channel MSB = base; lower COLOR_BITS-1 bits all = base & intensity.
- Reset:
  - h = v = 0; all pipeline stages cleared.
  - RGB = 0, de_o = 0, frame_start_o = 0, cell_addr = 0, font_addr = 0, hsync/vsync = !SYNC_POL.
  - Blink state = visible, frame counter = 0.
  - Reset asserted mid-frame: next cycle shows reset values; the frame restarts at (0,0) on the cycle after release, and the first valid pixel appears 5 cycles later.
- cursor_col/cursor_row are sampled once per frame at counter (0,0). Changes mid-frame take effect next frame.

Optional Feature:
- Macro VGA_TEXT_CURSOR_EN.
- Defined: a frame counter toggles blink phase every BLINK_FRAMES frames (localparam 16).
- While the phase is visible, the cell at the sampled cursor position renders suby in {CHAR_H-2, CHAR_H-1} as all-fg.
- Not defined: no cursor logic; cursor ports are present but ignored.

Decomposition:
- Package vga_text_pkg holds:
  - attribute bit-position constants;
  - the attr-to-RGB decode function (parametrised by COLOR_BITS);
  - default 640x480@60 timing constants;
  - pipeline latency constant (5).
- Sub-module vga_timing_gen: h/v counters, sync and active generation, col/row/subx/suby sub-counters, frame_start.

Test Plan:
- Reset mid-line (rst_n low 3 cycles at h=300): outputs hold reset values; after release, frame_start_o pulses at cycle 5 with de_o=1 and cell_addr=0.
- Default timing, line period: hsync_o low exactly 96 cycles beginning 656+5 cycles after each line start, 800 cycles per line; vsync_o low for lines 490-491, 525 lines per frame.
- Memory model: cell 0 = char 0x41, attr 0x9A; font row 0 = 0x01. Output pixel (0,0) = r0 g0 bF; pixels (1..7,0) = r0 gF b0 (bg green intense).
- Address mapping: at counter h=632 (col 79), v=464 (row 29) -> cell_addr = 2399; char 0x20, suby 0 -> font_addr = 0.
- ROWS=25 build: lines 400-479 output RGB=0 with de_o=1, and cell_addr stays 0.
- VGA_TEXT_CURSOR_EN with BLINK_FRAMES=2, cursor (5,3), blank font: pixels x 40-47, y 62-63 equal fg for 2 frames, then bg for 2 frames, repeating.
